// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and rising-to-rising period (in microseconds) of an
// asynchronous PWM line. Optional 8-cycle glitch filter: define PWM_CAPTURE_GLITCH_FILTER_EN.
module pwm_capture #(
   parameter int CLK_PER_US = 100,
   parameter int TIMEOUT_US = 50000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        enable,
   input  logic        pwm_in,
   output logic [15:0] dutty,
   output logic [15:0] period,
   output logic        valid,
   output logic        timeout
);

   localparam int              PS_W     = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
   localparam logic [PS_W-1:0] PS_LAST  = PS_W'(CLK_PER_US - 1);
   localparam logic [15:0]     TO_LIMIT = 16'(TIMEOUT_US);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_HIGH = 2'd1;
   localparam logic [1:0] S_LOW  = 2'd2;

   logic            r_sync1;
   logic            r_sync2;
   logic            r_lvl_d;
   logic            r_rise;
   logic            r_fall;
   logic            w_lvl;
   logic            w_rise;
   logic            w_fall;

   logic [PS_W-1:0] r_ps;
   logic [15:0]     r_us;
   logic            w_wrap;
   logic [15:0]     w_us_next;
   logic            w_to_hit;

   logic [1:0]      r_state;
   logic [1:0]      w_state_nxt;
   logic            w_clr;
   logic            w_shadow_ld;
   logic            w_publish;
   logic            w_to_set;

   logic [15:0]     r_shadow;
   logic [15:0]     r_dutty;
   logic [15:0]     r_period;
   logic            r_valid;
   logic            r_timeout;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= pwm_in;
         r_sync2 <= r_sync1;
      end
   end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
   logic       r_filt;
   logic [2:0] r_stab;

   // Level follows sync2 only after it has held a new value for 8 consecutive cycles.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_filt <= 1'b0;
         r_stab <= 3'd0;
      end else if (r_sync2 == r_filt) begin
         r_stab <= 3'd0;
      end else if (r_stab == 3'd7) begin
         r_filt <= r_sync2;
         r_stab <= 3'd0;
      end else begin
         r_stab <= r_stab + 3'd1;
      end
   end

   assign w_lvl = r_filt;
`else
   assign w_lvl = r_sync2;
`endif

   assign w_rise = w_lvl & ~r_lvl_d;
   assign w_fall = ~w_lvl & r_lvl_d;

   // Edge pulses are registered once more so both edges reach the FSM with equal latency.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_lvl_d <= 1'b0;
         r_rise  <= 1'b0;
         r_fall  <= 1'b0;
      end else begin
         r_lvl_d <= w_lvl;
         r_rise  <= w_rise;
         r_fall  <= w_fall;
      end
   end

   assign w_wrap    = (r_ps == PS_LAST);
   assign w_us_next = (w_wrap && (r_us != 16'hFFFF)) ? r_us + 16'd1 : r_us;
   assign w_to_hit  = (r_us == TO_LIMIT);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_ps <= '0;
         r_us <= 16'd0;
      end else if (w_clr) begin
         r_ps <= '0;
         r_us <= 16'd0;
      end else begin
         r_ps <= w_wrap ? '0 : r_ps + PS_W'(1);
         r_us <= w_us_next;
      end
   end

   // Edges take priority over timeout; disable overrides everything.
   always_comb begin
      w_state_nxt = r_state;
      w_clr       = 1'b0;
      w_shadow_ld = 1'b0;
      w_publish   = 1'b0;
      w_to_set    = 1'b0;
      if (!enable) begin
         w_state_nxt = S_IDLE;
         w_clr       = 1'b1;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (r_rise) begin
                  w_state_nxt = S_HIGH;
                  w_clr       = 1'b1;
               end else if (w_to_hit) begin
                  w_to_set = 1'b1;
                  w_clr    = 1'b1;
               end
            end
            S_HIGH: begin
               if (r_fall) begin
                  w_state_nxt = S_LOW;
                  w_shadow_ld = 1'b1;
               end else if (w_to_hit) begin
                  w_to_set    = 1'b1;
                  w_state_nxt = S_IDLE;
                  w_clr       = 1'b1;
               end
            end
            S_LOW: begin
               if (r_rise) begin
                  w_publish   = 1'b1;
                  w_state_nxt = S_HIGH;
                  w_clr       = 1'b1;
               end else if (w_to_hit) begin
                  w_to_set    = 1'b1;
                  w_state_nxt = S_IDLE;
                  w_clr       = 1'b1;
               end
            end
            default: begin
               w_state_nxt = S_IDLE;
               w_clr       = 1'b1;
            end
         endcase
      end
   end

   // Captured counts include the current cycle's tick so width = floor(cycles / CLK_PER_US).
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state   <= S_IDLE;
         r_shadow  <= 16'd0;
         r_dutty   <= 16'd0;
         r_period  <= 16'd0;
         r_valid   <= 1'b0;
         r_timeout <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_valid <= w_publish;
         if (w_shadow_ld) begin
            r_shadow <= w_us_next;
         end
         if (w_publish) begin
            r_dutty  <= r_shadow;
            r_period <= w_us_next;
         end
         if (!enable || w_publish) begin
            r_timeout <= 1'b0;
         end else if (w_to_set) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign dutty   = r_dutty;
   assign period  = r_period;
   assign valid   = r_valid;
   assign timeout = r_timeout;

endmodule
